gray_binary_converter_pipe: RTL



---
 rtl/gray_binary_converter_pipe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gray_binary_converter_pipe.sv
// gray_binary_converter_pipe
// Streaming binary<->Gray converter with a STAGES-deep register pipeline.
// Each word carries its own mode bit, so binary-to-Gray and Gray-to-binary
// words can be interleaved freely. The Gray-to-binary XOR chain is split
// across the stages (roughly WIDTH/STAGES bits each, MSB first); the
// binary-to-Gray conversion is a single XOR level and is done in stage 0.
//
// Handshake: a word moves on an edge where valid & ready are both high.
// in_ready is a combinational function of stage occupancy and out_ready,
// never of in_valid; out_valid never depends on out_ready. While
// out_valid=1 and out_ready=0 the presented word and mode hold stable.
module gray_binary_converter_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             busy
);

    // Index 0 is the upstream port; index k+1 is the content of stage k.
    logic [STAGES:0]  pv;
    logic [STAGES:0]  pm;
    logic [WIDTH-1:0] pd [STAGES+1];

    // Per-stage load enables (stage k captures its upstream word this edge).
    logic [STAGES-1:0] load;

    // Work done by stage k on a word travelling in the given mode.
    // Gray-to-binary: bit i is owned by stage ((WIDTH-1-i)*STAGES)/WIDTH,
    // so every stage sees all bits above its slice already in binary and
    // resolves its own slice MSB to LSB. The top bit is unchanged.
    function automatic logic [WIDTH-1:0] stage_fn(
        input int               k,
        input logic             mode,
        input logic [WIDTH-1:0] w
    );
        logic [WIDTH-1:0] r;
        r = w;
        if (!mode) begin
            if (k == 0) begin
                r = w ^ (w >> 1);
            end
        end else begin
            for (int i = WIDTH - 2; i >= 0; i--) begin
                if ((((WIDTH - 1 - i) * STAGES) / WIDTH) == k) begin
                    r[i] = r[i+1] ^ r[i];
                end
            end
        end
        return r;
    endfunction

    assign pv[0] = in_valid;
    assign pm[0] = in_mode;
    assign pd[0] = in_data;

    // Ready chain: a stage may load when any stage from itself to the end is
    // empty, or the downstream consumer is taking the last word this cycle.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        load      = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_tail = full_tail & pv[k+1];
            load[k]   = out_ready | ~full_tail;
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < STAGES; gk++) begin : g_stage
            logic             vld_q, vld_d;
            logic             mode_q, mode_d;
            logic [WIDTH-1:0] data_q, data_d;

            // Next-state for this stage: clear on reset, otherwise shift in
            // the upstream word; payload only changes when a real word lands.
            always_comb begin
                vld_d  = vld_q;
                mode_d = mode_q;
                data_d = data_q;
                if (rst) begin
                    vld_d  = 1'b0;
                    mode_d = 1'b0;
                    data_d = '0;
                end else if (load[gk]) begin
                    vld_d = pv[gk];
                    if (pv[gk]) begin
                        mode_d = pm[gk];
                        data_d = stage_fn(gk, pm[gk], pd[gk]);
                    end
                end
            end

            // Stage register.
            always_ff @(posedge clk) begin
                vld_q  <= vld_d;
                mode_q <= mode_d;
                data_q <= data_d;
            end

            assign pv[gk+1] = vld_q;
            assign pm[gk+1] = mode_q;
            assign pd[gk+1] = data_q;
        end
    endgenerate

    assign in_ready  = load[0] & ~rst;
    assign out_valid = pv[STAGES];
    assign out_mode  = pm[STAGES];
    assign out_data  = pd[STAGES];
    assign busy      = |pv[STAGES:1];

endmodule
